// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// STATUS bit positions and a helper that assembles the STATUS word.
package dmem_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_COUNTER = 2'd2;
  localparam logic [1:0] OFF_LEDS    = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  // STATUS read value: {29'b0, overflow, full, empty}
  function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                              input logic empty);
    logic [31:0] w;
    w = '0;
    w[ST_EMPTY] = empty;
    w[ST_FULL]  = full;
    w[ST_OVF]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor data-memory bus plus the TX byte stream and LED outputs.
//
// Handshake: tx_valid/tx_data/tx_ready follow strict valid/ready semantics.
// A byte transfers on a rising edge where tx_valid and tx_ready are both 1.
// While tx_valid is 1, tx_data stays stable until the transfer happens;
// tx_valid never depends combinationally on tx_ready.
interface dmem_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [15:0] leds;

  // Processor/downstream side
  modport master (
    output address_dmem, data, wren, tx_ready,
    input  q_dmem, tx_valid, tx_data, leds
  );

  // Responder side
  modport slave (
    input  address_dmem, data, wren, tx_ready,
    output q_dmem, tx_valid, tx_data, leds
  );
endinterface

// File: rtl/tx_fifo.sv
// Circular-buffer byte FIFO. A push while full is accepted only when a pop
// happens in the same cycle. The head output holds the last popped value
// once the FIFO drains, and reads 0 straight after reset.
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] last_head;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? last_head : mem[rd_ptr];

  // Pointer, occupancy and held-head bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) begin
        rd_ptr    <= rd_ptr + PW'(1);
        last_head <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset because empty masks them
  always_ff @(posedge clock) begin
    if (!reset && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, four MMIO registers (TX FIFO data,
// STATUS, free-running COUNTER, LEDS) and a registered read port.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH      = 4096,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_F000,
  parameter int          FIFO_DEPTH = 8
) (
  input logic              clock,
  input logic              reset,
  dmem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] ram [DEPTH];
  logic [31:0] mmio_rel;
  logic [1:0]  off;
  logic        is_ram;
  logic        is_mmio;
  logic        wr_ram;
  logic        wr_tx;
  logic        wr_status;
  logic        wr_counter;
  logic        wr_leds;
  logic        fifo_pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic        ovf_set;
  logic        overflow;
  logic [31:0] counter;
  logic [15:0] leds_r;
  logic [31:0] q_r;
  logic [31:0] rdata;
  logic [7:0]  fifo_head;

  // Address decode; the relative offset avoids overflow near the top of space
  assign mmio_rel   = bus.address_dmem - MMIO_BASE;
  assign is_ram     = (bus.address_dmem < 32'(DEPTH));
  assign is_mmio    = (bus.address_dmem >= MMIO_BASE) && (mmio_rel < 32'd4);
  assign off        = mmio_rel[1:0];

  assign wr_ram     = bus.wren & is_ram;
  assign wr_tx      = bus.wren & is_mmio & (off == OFF_TXDATA);
  assign wr_status  = bus.wren & is_mmio & (off == OFF_STATUS);
  assign wr_counter = bus.wren & is_mmio & (off == OFF_COUNTER);
  assign wr_leds    = bus.wren & is_mmio & (off == OFF_LEDS);

  assign fifo_pop   = ~fifo_empty & bus.tx_ready;
  assign ovf_set    = wr_tx & fifo_full & ~fifo_pop;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_tx),
    .push_data (bus.data[7:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Read mux built from pre-edge state
  always_comb begin
    rdata = '0;
    if (is_ram) begin
      rdata = ram[bus.address_dmem[AW-1:0]];
    end else if (is_mmio) begin
      case (off)
        OFF_STATUS:  rdata = status_word(overflow, fifo_full, fifo_empty);
        OFF_COUNTER: rdata = counter;
        OFF_LEDS:    rdata = {16'b0, leds_r};
        default:     rdata = '0;
      endcase
    end
  end

  // RAM write; contents survive reset, stores in a reset cycle are dropped
  always_ff @(posedge clock) begin
    if (!reset && wr_ram) ram[bus.address_dmem[AW-1:0]] <= bus.data;
  end

  // Registers: read data, overflow flag, cycle counter, LEDs
  always_ff @(posedge clock) begin
    if (reset) begin
      q_r      <= '0;
      overflow <= 1'b0;
      counter  <= '0;
      leds_r   <= '0;
    end else begin
      q_r <= rdata;
      if (ovf_set)        overflow <= 1'b1;
      else if (wr_status) overflow <= 1'b0;
      if (wr_counter) counter <= bus.data;
      else            counter <= counter + 32'd1;
      if (wr_leds) leds_r <= bus.data[15:0];
    end
  end

  assign bus.q_dmem   = q_r;
  assign bus.tx_valid = ~fifo_empty;
  assign bus.tx_data  = fifo_head;
  assign bus.leds     = leds_r;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the processor's data-memory interface (`address_dmem`, `data`, `wren`, `q_dmem`).
- Holds the word-addressed data RAM and a small memory-mapped I/O window:
  - byte transmit FIFO with valid/ready output to a downstream serializer
  - status register
  - free-running cycle counter
  - LED register
- Instantiated in the Wrapper beside the processor, in place of a bare RAM.

Parameters:
- DEPTH, 4096, number of 32-bit RAM words; RAM occupies word addresses 0..DEPTH-1.
- MMIO_BASE, 32'h0000_F000, word address of the first MMIO register; must be >= DEPTH.
- FIFO_DEPTH, 8, TX FIFO entries; power of two.

Ports:
- clock  input  1  master clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- address_dmem  input  32  word address from processor memory stage.
- data  input  32  store data from processor.
- wren  input  1  store enable.
- q_dmem  output  32  registered read data.
- tx_valid  output  1  TX FIFO non-empty.
- tx_data  output  8  head byte of TX FIFO.
- tx_ready  input  1  downstream accepts head byte this cycle.
- leds  output  16  LED register contents.

Behaviour:
- Reset (synchronous, on the rising edge with reset=1):
  - q_dmem=0, FIFO emptied, tx_valid=0, tx_data=0, overflow=0, counter=0, leds=0.
  - RAM contents are not cleared.
  - Any store presented in the reset cycle is ignored.
- Address decode:
  - RAM: address < DEPTH.
  - MMIO: address in MMIO_BASE..MMIO_BASE+3.
  - Anything else is unmapped: reads return 0, writes are ignored.
- Read latency is 1 cycle: q_dmem at edge N+1 holds the data for the address present at edge N.
- A read and a write to the same location at the same edge return the old data (read-before-write).
- RAM: when wren=1 and the address is mapped to RAM, `data` is written at the edge.
- MMIO map (offset from MMIO_BASE):
  - +0 TXDATA:
    - Write pushes `data[7:0]`.
    - Push while full is dropped and sets overflow.
    - Exception: full with a pop in the same cycle accepts the push and does not set overflow.
    - Read returns 0.
  - +1 STATUS:
    - Read returns {29'b0, overflow, full, empty}.
    - Any write clears overflow.
    - A clear and a new overflow in the same cycle: overflow ends at 1.
  - +2 COUNTER:
    - Increments by 1 every non-reset cycle; wraps 32'hFFFF_FFFF -> 0.
    - Write loads `data` at that edge, with no increment that cycle.
    - Read returns the pre-edge value.
  - +3 LEDS: write loads `data[15:0]`; read returns {16'b0, leds}.
- TX FIFO:
  - Circular buffer: read/write pointers plus a count of width log2(FIFO_DEPTH)+1.
  - tx_valid = (count != 0); tx_data = mem[rd_ptr], combinational from FIFO state.
  - Pop occurs when tx_valid & tx_ready.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
  - If empty, a push and tx_ready in the same cycle do not bypass: the byte appears on tx_data the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - tx_data holds its value when the FIFO is empty; it is 0 only after reset.
- Status flags are derived from the pre-edge state: empty = (count==0), full = (count==FIFO_DEPTH).

Decomposition:
- Shared package `dmem_pkg`:
  - MMIO offset constants: OFF_TXDATA=0, OFF_STATUS=1, OFF_COUNTER=2, OFF_LEDS=3.
  - STATUS bit indices: ST_EMPTY=0, ST_FULL=1, ST_OVF=2.
- One sub-module, `tx_fifo`:
  - Parameterised by FIFO_DEPTH and width 8.
  - Ports: clock, reset, push, push_data, pop, head, empty, full.
- The top level holds the RAM array, address decode, counter, LEDs, overflow and the q_dmem register.

Test Plan:
1. Reset, then write 32'hDEADBEEF to address 5, then read address 5 → q_dmem=32'hDEADBEEF one cycle after the read address; read address 6 (never written, reset-independent) → no X-propagation into logic; read unmapped 32'h0000_2000 → 0.
2. With tx_ready=0, write 0x41..0x48 to MMIO_BASE+0 (8 bytes), then write 0x49 → STATUS reads 3'b110 (overflow, full); raise tx_ready → tx_data 0x41..0x48 in order over 8 cycles, 0x49 never appears, then STATUS reads 3'b101; write STATUS → reads 3'b001.
3. FIFO full with tx_ready=1, push 0x55 in the same cycle → overflow stays 0; count stays 8; 0x55 emerges ninth.
4. After reset, read COUNTER at cycle 10 after reset deassertion → q_dmem=10; write 32'hFFFF_FFFE to COUNTER → two cycles later counter=0 (wrap).
5. Write 32'h0001_A5A5 to MMIO_BASE+3 → leds=16'hA5A5; read returns 32'h0000_A5A5; assert reset mid-sequence with a pending TX push and a LEDS write in the same cycle → leds=0, FIFO empty, write ignored.
6. Back-to-back write 7 then read address 7 on the next cycle, plus a simultaneous read/write of the same address → the next-cycle read returns new data; the simultaneous access returns old data.
